soml_frame_sequencer: RTL and testbench

- Frame-level controller between the UART word receiver and the SOML decoder datapath.
- Collects one 48-word frame (16 complex H entries, then Y1/Y2 as 8 complex entries), writes it into the H/Y register file and conditions the Y imaginary words.
- Fires one calculation start, waits for the decoder result with a watchdog, and hands the 12-bit message to the UART transmitter.

---
 rtl/soml_pkg.sv | 32 +++
 rtl/soml_watchdog.sv | 42 ++++
 rtl/soml_frame_sequencer.sv | 165 ++++++++++++++++
 tb/tb_soml_frame_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/soml_pkg.sv
// ============================================================================
// Module      : soml_pkg
// Description : Shared state encoding, frame layout and message width for the
//               SOML frame sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package soml_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_SEND  = 3'd4
    } state_t;

    localparam int ADDR_W    = 6;
    localparam int H_WORDS   = 32;
    localparam int Y_BASE    = 32;
    localparam int NUM_WORDS = 48;
    localparam int MSG_W     = 12;

    // Odd addresses in the Y region hold imaginary parts, which are stored negated.
    function automatic logic is_y_imag(input logic [ADDR_W-1:0] addr);
        return (addr >= ADDR_W'(Y_BASE)) && addr[0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/soml_watchdog.sv
// ============================================================================
// Module      : soml_watchdog
// Description : Loadable up-counter with clear and enable; stops at TERMINAL
//               and flags it on tc.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module soml_watchdog #(
    parameter int WIDTH    = 12,
    parameter int TERMINAL = 4095
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             tc
);

    localparam logic [WIDTH-1:0] C_TERM = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && !tc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tc = (r_count == C_TERM);

endmodule

`default_nettype wire

// File: rtl/soml_frame_sequencer.sv
// ============================================================================
// Module      : soml_frame_sequencer
// Description : Loads one 48-word H/Y frame into the register file, starts the
//               SOML decoder under a watchdog and forwards its message to the
//               UART transmitter. SOML_LOAD_GAP_TIMEOUT_EN adds an inter-word
//               gap timeout while loading.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module soml_frame_sequencer
    import soml_pkg::*;
#(
    parameter int N            = 32,
    parameter int NUM_WORDS    = soml_pkg::NUM_WORDS,
    parameter int CALC_TIMEOUT = 4096,
    parameter int GAP_CYCLES   = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [N-1:0]     in_data,
    output logic             in_ready,
    output logic             wr_en,
    output logic [5:0]       wr_addr,
    output logic [N-1:0]     wr_data,
    output logic             calc_start,
    input  logic             calc_done,
    input  logic [MSG_W-1:0] result_in,
    input  logic             tx_busy,
    output logic [MSG_W-1:0] tx_msg,
    output logic             tx_msg_valid,
    output logic             timeout_err,
    output logic             frame_abort,
    output logic [2:0]       state_o
);

    localparam int              CALC_W = (CALC_TIMEOUT > 2) ? $clog2(CALC_TIMEOUT) : 1;
    localparam logic [5:0]      C_LAST = 6'(NUM_WORDS - 1);

    state_t     r_state;
    logic [5:0] r_cnt;
    logic       w_calc_tc;

    soml_watchdog #(
        .WIDTH    (CALC_W),
        .TERMINAL (CALC_TIMEOUT - 1)
    ) u_calc_wd (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (r_state == ST_START),
        .load     (1'b0),
        .load_val ({CALC_W{1'b0}}),
        .en       (r_state == ST_WAIT),
        .tc       (w_calc_tc)
    );

`ifdef SOML_LOAD_GAP_TIMEOUT_EN
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    logic w_gap_tc;

    soml_watchdog #(
        .WIDTH    (GAP_W),
        .TERMINAL (GAP_CYCLES)
    ) u_gap_wd (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (in_valid || (r_state != ST_LOAD)),
        .load     (1'b0),
        .load_val ({GAP_W{1'b0}}),
        .en       ((r_state == ST_LOAD) && (r_cnt != 6'd0)),
        .tc       (w_gap_tc)
    );
`else
    logic w_gap_unused;
    assign w_gap_unused = (GAP_CYCLES != 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            in_ready     <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            calc_start   <= 1'b0;
            tx_msg       <= '0;
            tx_msg_valid <= 1'b0;
            timeout_err  <= 1'b0;
            frame_abort  <= 1'b0;
        end else begin
            wr_en        <= 1'b0;
            calc_start   <= 1'b0;
            tx_msg_valid <= 1'b0;
            frame_abort  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    r_state  <= ST_LOAD;
                    // A word landing here is word 0, so nothing is dropped on the way into LOAD.
                    if (in_valid) begin
                        wr_en   <= 1'b1;
                        wr_addr <= '0;
                        wr_data <= in_data;
                        r_cnt   <= 6'd1;
                    end else begin
                        r_cnt   <= '0;
                    end
                end

                ST_LOAD: begin
                    if (in_valid) begin
                        wr_en   <= 1'b1;
                        wr_addr <= r_cnt;
                        wr_data <= is_y_imag(r_cnt) ? -in_data : in_data;
                        r_cnt   <= r_cnt + 6'd1;
                        if (r_cnt == C_LAST) begin
                            in_ready <= 1'b0;
                            r_state  <= ST_START;
                        end
                    end
`ifdef SOML_LOAD_GAP_TIMEOUT_EN
                    else if (w_gap_tc) begin
                        frame_abort <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
`endif
                end

                ST_START: begin
                    calc_start <= 1'b1;
                    r_state    <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (calc_done) begin
                        tx_msg  <= result_in;
                        r_state <= ST_SEND;
                    end else if (w_calc_tc) begin
                        timeout_err <= 1'b1;
                        frame_abort <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                ST_SEND: begin
                    if (!tx_busy) begin
                        tx_msg_valid <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign state_o = r_state;

endmodule

`default_nettype wire

// File: tb/tb_soml_frame_sequencer.sv
// ============================================================================
// Module      : tb_soml_frame_sequencer
// Description : Directed self-checking bench for soml_frame_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_soml_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        calc_start;
    logic        calc_done;
    logic [11:0] result_in;
    logic        tx_busy;
    logic [11:0] tx_msg;
    logic        tx_msg_valid;
    logic        timeout_err;
    logic        frame_abort;
    logic [2:0]  state_o;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] wmem [0:47];

    always #5 clk = ~clk;

    soml_frame_sequencer #(
        .N            (32),
        .NUM_WORDS    (48),
        .CALC_TIMEOUT (16),
        .GAP_CYCLES   (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .calc_start   (calc_start),
        .calc_done    (calc_done),
        .result_in    (result_in),
        .tx_busy      (tx_busy),
        .tx_msg       (tx_msg),
        .tx_msg_valid (tx_msg_valid),
        .timeout_err  (timeout_err),
        .frame_abort  (frame_abort),
        .state_o      (state_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_word(input int k, input logic [31:0] v);
        return (k >= 32 && (k % 2) == 1) ? (32'd0 - v) : v;
    endfunction

    task automatic send_word(input int k, input logic [31:0] v);
        in_valid = 1'b1;
        in_data  = v;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        chk("wr_en", 32'(wr_en), 32'd1);
        chk("wr_addr", 32'(wr_addr), 32'(k));
        chk("wr_data", wr_data, exp_word(k, v));
        wmem[k] = wr_data;
    endtask

    // Loads a full frame (word k = base+k+1) and stops in the calc_start cycle.
    task automatic load_frame(input int base);
        for (int k = 0; k < 48; k++) begin
            send_word(k, 32'(base + k + 1));
            if (k != 47) tick();
        end
        chk("start_state", 32'(state_o), 32'd2);
        chk("in_ready_drop", 32'(in_ready), 32'd0);
        chk("calc_start_early", 32'(calc_start), 32'd0);
        tick();
        chk("calc_start", 32'(calc_start), 32'd1);
        chk("wait_state", 32'(state_o), 32'd3);
    endtask

    task automatic finish_calc(input logic [11:0] msg);
        calc_done = 1'b1;
        result_in = msg;
        tick();
        calc_done = 1'b0;
        chk("calc_start_single", 32'(calc_start), 32'd0);
        chk("send_state", 32'(state_o), 32'd4);
        chk("tx_msg_latch", 32'(tx_msg), 32'(msg));
        chk("tx_valid_early", 32'(tx_msg_valid), 32'd0);
        tick();
        chk("tx_valid", 32'(tx_msg_valid), 32'd1);
        chk("idle_after_send", 32'(state_o), 32'd0);
        tick();
        chk("tx_valid_single", 32'(tx_msg_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        calc_done = 1'b0;
        result_in = '0;
        tx_busy   = 1'b0;
        tick(); tick(); tick();

        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_calc_start", 32'(calc_start), 32'd0);
        chk("rst_tx_msg", 32'(tx_msg), 32'd0);
        chk("rst_tx_valid", 32'(tx_msg_valid), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        chk("rst_abort", 32'(frame_abort), 32'd0);
        rst_n = 1'b1;

        // Frame 1: word 0 arrives while still in IDLE.
        load_frame(0);
        chk("mem31", wmem[31], 32'd32);
        chk("mem32", wmem[32], 32'd33);
        chk("mem33", wmem[33], 32'hFFFF_FFDE);
        chk("mem46", wmem[46], 32'd47);
        chk("mem47", wmem[47], 32'hFFFF_FFD0);
        finish_calc(12'hA5C);

        // calc_done outside WAIT must be ignored.
        calc_done = 1'b1;
        result_in = 12'h111;
        tick();
        calc_done = 1'b0;
        chk("stray_done_msg", 32'(tx_msg), 32'h0000_0A5C);
        chk("stray_done_state", 32'(state_o), 32'd1);

        // Frame 2: transmitter busy for 10 cycles after calc_done.
        load_frame(100);
        tx_busy   = 1'b1;
        calc_done = 1'b1;
        result_in = 12'h3C7;
        tick();
        calc_done = 1'b0;
        chk("busy_send_state", 32'(state_o), 32'd4);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("busy_no_valid", 32'(tx_msg_valid), 32'd0);
            chk("busy_msg_hold", 32'(tx_msg), 32'h0000_03C7);
        end
        tx_busy = 1'b0;
        tick();
        chk("busy_release_valid", 32'(tx_msg_valid), 32'd1);
        chk("busy_release_msg", 32'(tx_msg), 32'h0000_03C7);
        tick();
        chk("busy_valid_single", 32'(tx_msg_valid), 32'd0);

        // Frame 3: no calc_done; stray words in WAIT; watchdog fires 16 cycles after calc_start.
        load_frame(200);
        for (int k = 1; k <= 15; k++) begin
            in_valid = (k <= 5);
            in_data  = 32'hDEAD_0000 + 32'(k);
            tick();
            chk("wait_no_write", 32'(wr_en), 32'd0);
            chk("wait_no_abort", 32'(frame_abort), 32'd0);
            chk("wait_hold", 32'(state_o), 32'd3);
        end
        in_valid = 1'b0;
        in_data  = '0;
        tick();
        chk("to_abort", 32'(frame_abort), 32'd1);
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_idle", 32'(state_o), 32'd0);
        tick();
        chk("to_abort_single", 32'(frame_abort), 32'd0);
        chk("to_err_sticky", 32'(timeout_err), 32'd1);

        load_frame(300);
        finish_calc(12'h5A1);
        chk("to_err_sticky2", 32'(timeout_err), 32'd1);

        // Reset mid-LOAD right after word 20 was written.
        for (int k = 0; k <= 20; k++) begin
            send_word(k, 32'(400 + k + 1));
            if (k != 20) tick();
        end
        rst_n = 1'b0;
        #2;
        chk("arst_wr_en", 32'(wr_en), 32'd0);
        chk("arst_wr_addr", 32'(wr_addr), 32'd0);
        chk("arst_wr_data", wr_data, 32'd0);
        chk("arst_state", 32'(state_o), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        chk("arst_timeout", 32'(timeout_err), 32'd0);
        chk("arst_tx_msg", 32'(tx_msg), 32'd0);
        tick();
        rst_n = 1'b1;
        load_frame(500);
        finish_calc(12'h0F0);

`ifdef SOML_LOAD_GAP_TIMEOUT_EN
        // Partial frame of 10 words, then silence until the gap timer expires.
        for (int k = 0; k < 10; k++) begin
            send_word(k, 32'(700 + k + 1));
            if (k != 9) tick();
        end
        for (int j = 1; j <= 8; j++) begin
            tick();
            chk("gap_no_abort", 32'(frame_abort), 32'd0);
        end
        tick();
        chk("gap_abort", 32'(frame_abort), 32'd1);
        chk("gap_idle", 32'(state_o), 32'd0);
        load_frame(600);
        finish_calc(12'h777);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
